// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one add/sub datapath among NUM_REQ requesters.
// Operands are registered, the adder gets a full EXEC cycle, and the result comes back tagged with the requester ID.

module add #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] b_eff;

  // Subtraction is A + ~B + 1, with the +1 entering as the carry-in
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + WIDTH'(sub);

endmodule

module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_ovf,
  output logic [31:0]              op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic [WIDTH-1:0] a_q, b_q, sum, b_eff_q;
  logic             sub_q;
  logic [IDW-1:0]   id_q;
  logic             ovf;
  int               idx;

  // Search starts one past the last winner and wraps, so the first hit is the fairest choice
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready = (state == IDLE && !rst) ? grant_oh : '0;
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  add #(.WIDTH(WIDTH)) u_add (
    .a   (a_q),
    .b   (b_q),
    .sub (sub_q),
    .sum (sum)
  );

  assign b_eff_q = sub_q ? ~b_q : b_q;
  assign ovf     = (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

  // Only the latched operands feed the adder; its output is captured at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      id_q       <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_ovf    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          a_q        <= req_a[grant_idx*WIDTH +: WIDTH];
          b_q        <= req_b[grant_idx*WIDTH +: WIDTH];
          sub_q      <= req_sub[grant_idx];
          id_q       <= grant_idx;
          last_grant <= grant_idx;
        end
        EXEC: begin
          rsp_result <= sum;
          rsp_id     <= id_q;
          rsp_ovf    <= ovf;
        end
        RESP: if (rsp_ready) op_count <= op_count + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: stimulus pushes expected responses into a scoreboard,
// a negedge monitor pops and compares on every response handshake.

module tb_alu_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 64;
  localparam int IDW     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_sub;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_ovf;
  logic [31:0]              op_count;

  int         check_count = 0;
  int         pass_count  = 0;
  int         exp_id_q[$];
  logic [63:0] exp_res_q[$];
  logic       exp_ovf_q[$];

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic note_fail(input string name);
    check_count++;
    $display("[TB] FAIL %s: timed out / unexpected event", name);
  endtask

  task automatic push_expected(input int id, input logic [63:0] res, input logic ovf);
    exp_id_q.push_back(id);
    exp_res_q.push_back(res);
    exp_ovf_q.push_back(ovf);
  endtask

  task automatic set_operands(input int idx, input logic [63:0] a, input logic [63:0] b, input logic sub);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_sub[idx]              = sub;
  endtask

  // Waits for any grant within a bounded window and compares the one-hot pattern
  task automatic wait_grant(input string name, input logic [NUM_REQ-1:0] expected);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = 1'b1;
        check_output(name, 64'(req_ready), 64'(expected));
      end
    end
    if (!seen) note_fail(name);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 50 && exp_res_q.size() != 0; c++) @(posedge clk);
    if (exp_res_q.size() != 0) note_fail(name);
  endtask

  // Single requester issue, with grant width and two-cycle latency checks
  task automatic apply_stimulus(input int idx, input logic [63:0] a, input logic [63:0] b,
                                input logic sub, input logic [63:0] exp_res, input logic exp_ovf);
    @(posedge clk); #1;
    set_operands(idx, a, b, sub);
    req_valid[idx] = 1'b1;
    push_expected(idx, exp_res, exp_ovf);
    wait_grant("grant", NUM_REQ'(1) << idx);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk);
    check_output("ready_one_cycle", 64'(req_ready), 64'(0));
    check_output("valid_not_early", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    check_output("latency_valid", 64'(rsp_valid), 64'(1));
    @(posedge clk);
  endtask

  always @(negedge clk) begin : monitor
    int          eid;
    logic [63:0] eres;
    logic        eovf;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_res_q.size() == 0) note_fail("unexpected_rsp");
      else begin
        eid  = exp_id_q.pop_front();
        eres = exp_res_q.pop_front();
        eovf = exp_ovf_q.pop_front();
        check_output("rsp_id", 64'(rsp_id), 64'(eid));
        check_output("rsp_result", rsp_result, eres);
        check_output("rsp_ovf", 64'(rsp_ovf), 64'(eovf));
      end
    end
  end

  initial begin : watchdog
    #400000;
    note_fail("watchdog");
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin : stimulus
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int g;

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_ready", 64'(req_ready), 64'(0));
    check_output("reset_valid", 64'(rsp_valid), 64'(0));
    check_output("reset_result", rsp_result, 64'(0));
    check_output("reset_id", 64'(rsp_id), 64'(0));
    check_output("reset_count", 64'(op_count), 64'(0));
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    apply_stimulus(0, 64'd5, 64'd3, 1'b0, 64'd8, 1'b0);
    #1;
    check_output("count_after_first", 64'(op_count), 64'(1));
    apply_stimulus(2, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    apply_stimulus(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
    apply_stimulus(3, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

    // Backpressure: result held while a second requester waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_operands(1, 64'h10, 64'h20, 1'b0);
    req_valid[1] = 1'b1;
    push_expected(1, 64'h30, 1'b0);
    wait_grant("bp_grant", 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_operands(2, 64'h1234, 64'h34, 1'b1);
    req_valid[2] = 1'b1;
    push_expected(2, 64'h1200, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("bp_valid", 64'(rsp_valid), 64'(1));
      check_output("bp_result", rsp_result, 64'h30);
      check_output("bp_id", 64'(rsp_id), 64'(1));
      check_output("bp_ready_low", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    wait_grant("bp_next_grant", 4'b0100);
    check_output("bp_idle_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    drain("bp_drain");
    @(posedge clk); #1;
    check_output("count_before_reset", 64'(op_count), 64'(6));

    // Fairness from reset with all requesters holding valid
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_operands(i, 64'(100 * (i + 1)), 64'(i + 1), 1'b0);
    foreach (order[k]) push_expected(order[k], 64'(101 * (order[k] + 1)), 1'b0);
    req_valid = '1;
    g = 0;
    for (int c = 0; c < 80 && g < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check_output("fair_grant", 64'(req_ready), 64'(1) << order[g]);
        g++;
      end
    end
    if (g < 6) note_fail("fair_timeout");
    @(posedge clk); #1;
    req_valid = '0;
    drain("fair_drain");

    // Wrap from requester 3 to requester 1 with only 1 and 3 active
    @(posedge clk); #1;
    req_valid = 4'b1000;
    push_expected(3, 64'd404, 1'b0);
    wait_grant("only3_grant", 4'b1000);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    push_expected(1, 64'd202, 1'b0);
    wait_grant("wrap_grant", 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    drain("wrap_drain");
    @(posedge clk); #1;
    check_output("count_after_fair", 64'(op_count), 64'(8));

    // Reset during EXEC discards the op
    @(posedge clk); #1;
    set_operands(0, 64'd1, 64'd1, 1'b0);
    req_valid[0] = 1'b1;
    wait_grant("midop_grant", 4'b0001);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_output("midop_valid", 64'(rsp_valid), 64'(0));
    check_output("midop_count", 64'(op_count), 64'(0));
    check_output("midop_ready", 64'(req_ready), 64'(0));
    set_operands(3, 64'd9, 64'd9, 1'b0);
    req_valid = 4'b1001;
    @(posedge clk); #1;
    rst = 1'b0;
    push_expected(0, 64'd2, 1'b0);
    wait_grant("post_reset_grant", 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    drain("final_drain");
    @(posedge clk); #1;
    check_output("final_count", 64'(op_count), 64'(1));
    repeat (4) @(negedge clk);
    check_output("final_idle_valid", 64'(rsp_valid), 64'(0));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
